// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the FIFO write arbiter: FSM encoding, stall-counter
// ceiling and default widths.
package fifo_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        STALL = 2'd2
    } state_e;

    localparam logic [7:0] STALL_MAX      = 8'd255;
    localparam int         DEF_DATO_WIDTH = 3;
    localparam int         DEF_NUM_REQ    = 4;

endpackage

// File: rtl/rr_pick.sv
// Round-robin search: first set req bit after the last winner lp, wrapping
// modulo NUM_REQ. Purely combinational.
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter  int NUM_REQ = DEF_NUM_REQ,
    localparam int PW      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PW-1:0]      lp,
    output logic               any,
    output logic [PW-1:0]      w
);

    // Scan from the farthest candidate down to lp+1 so the nearest one wins last.
    always_comb begin
        // NOTE: every output gets a default before the loop, so no path leaves a latch.
        any = 1'b0;
        w   = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            if (req[(int'(lp) + k) % NUM_REQ]) begin
                any = 1'b1;
                w   = PW'((int'(lp) + k) % NUM_REQ);
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Arbitrates NUM_REQ write requesters onto one FIFO write port with a
// round-robin pick, a one-cycle registered strobe and a stall counter.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int DATO_WIDTH = DEF_DATO_WIDTH,
    parameter int NUM_REQ    = DEF_NUM_REQ
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATO_WIDTH-1:0] datin,
    input  logic                          full,
    output logic [NUM_REQ-1:0]            gnt,
    output logic                          fifo_wr,
    output logic [DATO_WIDTH-1:0]         fifo_datin,
    output logic [7:0]                    stall_cnt
);

    localparam int            PW      = $clog2(NUM_REQ);
    localparam logic [PW-1:0] LP_INIT = PW'(NUM_REQ - 1);

    state_e                  state_q, state_d;
    logic [PW-1:0]           lp_q, lp_d;
    logic [NUM_REQ-1:0]      gnt_q, gnt_d;
    logic                    wr_q, wr_d;
    logic [DATO_WIDTH-1:0]   dat_q, dat_d;
    logic [7:0]              stall_q, stall_d;

    logic                    req_any;
    logic [PW-1:0]           win;
    logic                    grant_now;

    rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .req (req),
        .lp  (lp_q),
        .any (req_any),
        .w   (win)
    );

    // State register and all registered outputs share one asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: non-blocking assignments for every flop, so all state samples the same edge.
            state_q <= IDLE;
            lp_q    <= LP_INIT;
            gnt_q   <= '0;
            wr_q    <= 1'b0;
            dat_q   <= '0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            lp_q    <= lp_d;
            gnt_q   <= gnt_d;
            wr_q    <= wr_d;
            dat_q   <= dat_d;
            stall_q <= stall_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req_any) state_d = full ? STALL : GRANT;
            GRANT:   state_d = IDLE;
            STALL: begin
                if (!req_any)  state_d = IDLE;
                else if (!full) state_d = GRANT;
            end
            default: state_d = IDLE;
        endcase
    end

    // full is only looked at here, on the deciding edge, so a strobe never follows a full sample.
    assign grant_now = (state_q == IDLE || state_q == STALL) && req_any && !full;

    always_comb begin
        gnt_d   = '0;
        wr_d    = 1'b0;
        dat_d   = '0;
        lp_d    = lp_q;
        stall_d = stall_q;
        if (grant_now) begin
            gnt_d = NUM_REQ'(1) << win;
            wr_d  = 1'b1;
            dat_d = datin[int'(win) * DATO_WIDTH +: DATO_WIDTH];
            lp_d  = win;
        end
        if (state_q == STALL && req_any && full && stall_q != STALL_MAX) begin
            stall_d = stall_q + 8'd1;
        end
    end

    assign gnt        = gnt_q;
    assign fifo_wr    = wr_q;
    assign fifo_datin = dat_q;
    assign stall_cnt  = stall_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: reset, round-robin order, single grant,
// full stall, withdrawal, saturation and asynchronous reset during a grant.
module tb_fifo_wr_arbiter;

    localparam int DW = 3;
    localparam int NR = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [NR-1:0]    req;
    logic [NR*DW-1:0] datin;
    logic             full;
    logic [NR-1:0]    gnt;
    logic             fifo_wr;
    logic [DW-1:0]    fifo_datin;
    logic [7:0]       stall_cnt;

    int n_vec = 0;
    int n_err = 0;

    fifo_wr_arbiter #(.DATO_WIDTH(DW), .NUM_REQ(NR)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .datin      (datin),
        .full       (full),
        .gnt        (gnt),
        .fifo_wr    (fifo_wr),
        .fifo_datin (fifo_datin),
        .stall_cnt  (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, " gnt"}, 32'(gnt), 32'h0);
        check({tag, " wr"},  32'(fifo_wr), 32'h0);
    endtask

    initial begin
        logic saw_wr;
        int   order [5] = '{0, 1, 2, 3, 0};

        rst   = 1'b1;
        req   = '0;
        datin = '0;
        full  = 1'b0;

        // Reset state
        repeat (2) tick();
        check("rst gnt",   32'(gnt), 32'h0);
        check("rst wr",    32'(fifo_wr), 32'h0);
        check("rst datin", 32'(fifo_datin), 32'h0);
        check("rst stall", 32'(stall_cnt), 32'h0);
        rst = 1'b0;
        tick();
        check_idle("idle no req");

        // Fairness: all request, slice i holds word i+1; expect 0,1,2,3,0 every 2 cycles
        datin = {3'd4, 3'd3, 3'd2, 3'd1};
        req   = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            tick();
            check($sformatf("rr%0d gnt", g),   32'(gnt), 32'(1) << order[g]);
            check($sformatf("rr%0d wr", g),    32'(fifo_wr), 32'h1);
            check($sformatf("rr%0d datin", g), 32'(fifo_datin), 32'(order[g] + 1));
            if (g == 4) req = '0;
            tick();
            check_idle($sformatf("rr%0d gap", g));
        end

        // Single request from requester 2 with word 5 (lp is now 0)
        datin = 12'(5) << 6;
        req   = 4'b0100;
        tick();
        check("single gnt",   32'(gnt), 32'h4);
        check("single wr",    32'(fifo_wr), 32'h1);
        check("single datin", 32'(fifo_datin), 32'h5);
        req = '0;
        tick();
        check_idle("single after");
        check("single after datin", 32'(fifo_datin), 32'h0);
        check("single after stall", 32'(stall_cnt), 32'h0);

        // Full stall: first edge enters STALL, the next 10 edges each count
        datin = 12'(6) << 3;
        req   = 4'b0010;
        full  = 1'b1;
        tick();
        check_idle("stall enter");
        check("stall enter cnt", 32'(stall_cnt), 32'h0);
        saw_wr = 1'b0;
        repeat (10) begin
            tick();
            if (fifo_wr !== 1'b0) saw_wr = 1'b1;
        end
        check("stall no wr", 32'(saw_wr), 32'h0);
        check("stall cnt10", 32'(stall_cnt), 32'd10);
        full = 1'b0;
        tick();
        check("stall release gnt",   32'(gnt), 32'h2);
        check("stall release wr",    32'(fifo_wr), 32'h1);
        check("stall release datin", 32'(fifo_datin), 32'h6);
        req = '0;
        tick();
        check_idle("stall release after");

        // Withdrawal: stall once more, drop req, then re-request under full.
        // If IDLE was reached, the re-entry edge does not count.
        datin = 12'(3) << 9;
        req   = 4'b1000;
        full  = 1'b1;
        tick();
        tick();
        check("wd cnt11", 32'(stall_cnt), 32'd11);
        req = '0;
        tick();
        check_idle("wd drop");
        check("wd drop cnt", 32'(stall_cnt), 32'd11);
        req = 4'b1000;
        tick();
        check_idle("wd reenter");
        check("wd reenter cnt", 32'(stall_cnt), 32'd11);

        // Saturation: 300 more stalled edges
        saw_wr = 1'b0;
        repeat (300) begin
            tick();
            if (fifo_wr !== 1'b0) saw_wr = 1'b1;
        end
        check("sat no wr", 32'(saw_wr), 32'h0);
        check("sat cnt",   32'(stall_cnt), 32'd255);

        // Grant to requester 3, then reset asynchronously mid-GRANT
        full = 1'b0;
        tick();
        check("pre-rst gnt",   32'(gnt), 32'h8);
        check("pre-rst datin", 32'(fifo_datin), 32'h3);
        #2;
        rst = 1'b1;
        #1;
        check("async rst gnt",   32'(gnt), 32'h0);
        check("async rst wr",    32'(fifo_wr), 32'h0);
        check("async rst datin", 32'(fifo_datin), 32'h0);
        check("async rst stall", 32'(stall_cnt), 32'h0);
        req   = 4'b1111;
        datin = {3'd4, 3'd3, 3'd2, 3'd1};
        tick();
        rst = 1'b0;
        check("post-rst stall", 32'(stall_cnt), 32'h0);
        tick();
        check("post-rst first gnt", 32'(gnt), 32'h1);
        check("post-rst first wr",  32'(fifo_wr), 32'h1);
        req = '0;
        tick();
        check_idle("post-rst after");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 The module SHALL have parameter DATO_WIDTH, default 3, giving the data word width in bits.
REQ-002 The module SHALL have parameter NUM_REQ, default 4, giving the number of write requesters (legal range 2..8).
REQ-003 The module SHALL have input clk, 1 bit, the single clock; all state SHALL update on posedge clk.
REQ-004 The module SHALL have input rst, 1 bit, with asynchronous, active-high reset.
REQ-005 The module SHALL have input req, NUM_REQ bits, one write request per requester, held high until granted.
REQ-006 The module SHALL have input datin, NUM_REQ*DATO_WIDTH bits; requester i's word SHALL occupy bits [i*DATO_WIDTH +: DATO_WIDTH] and be held stable while req[i] is high.
REQ-007 The module SHALL have input full, 1 bit, the FIFO full flag.
REQ-008 The module SHALL have output gnt, NUM_REQ bits, a registered one-hot grant pulse.
REQ-009 The module SHALL have output fifo_wr, 1 bit, a registered one-cycle write strobe to the FIFO.
REQ-010 The module SHALL have output fifo_datin, DATO_WIDTH bits, the registered word for the FIFO, valid while fifo_wr is high.
REQ-011 The module SHALL have output stall_cnt, 8 bits, a saturating count of cycles spent in STALL.

Function
REQ-012 The FSM SHALL have three states: IDLE, GRANT and STALL.
REQ-013 In IDLE, at a clk edge with req==0, the FSM SHALL stay in IDLE with gnt=0 and fifo_wr=0.
REQ-014 In IDLE, at a clk edge with req!=0 and full==0, the FSM SHALL pick winner w, load gnt=1<<w, fifo_wr=1 and fifo_datin=datin slice w, and go to GRANT.
REQ-015 In IDLE, at a clk edge with req!=0 and full==1, the FSM SHALL go to STALL with gnt=0 and fifo_wr=0.
REQ-016 GRANT SHALL last exactly one cycle; at its end gnt and fifo_wr SHALL clear and the FSM SHALL return to IDLE, so writes occur at most every second cycle and requesters get one cycle to drop req.
REQ-017 In STALL, at each edge where full==1 and req!=0, stall_cnt SHALL increment, saturating at 255.
REQ-018 In STALL, at an edge where full==0 and req!=0, the FSM SHALL perform the REQ-014 grant and go to GRANT.
REQ-019 In STALL, at an edge where req==0 (all requests withdrawn), the FSM SHALL go to IDLE.
REQ-020 Arbitration SHALL be round-robin: a last-winner pointer lp (initially NUM_REQ-1) sets the search order lp+1, lp+2, … modulo NUM_REQ, and the first set req bit wins.
REQ-021 lp SHALL update to w only on a grant.
REQ-022 Latency SHALL be one cycle: a request sampled at edge k with full==0 in IDLE SHALL cause gnt and fifo_wr to be high from edge k to edge k+1.
REQ-023 full SHALL be sampled only at the decision edge; the arbiter SHALL never assert fifo_wr when full was 1 at that edge.
REQ-024 A req bit dropped before being granted SHALL be ignored, with no data loss reported.

Reset
REQ-025 While rst is high, the FSM SHALL be in IDLE and gnt=0, fifo_wr=0, fifo_datin=0, stall_cnt=0, lp=NUM_REQ-1, regardless of clk.
REQ-026 Reset asserted during GRANT SHALL abort the strobe immediately, asynchronously.
REQ-027 After rst is released, the first grant SHALL go to requester 0 if it requests.

Structure
REQ-028 A shared package fifo_arb_pkg SHALL hold the state encoding (IDLE=2'd0, GRANT=2'd1, STALL=2'd2), STALL_MAX=8'd255 and the default widths.
REQ-029 The round-robin search SHALL be one combinational sub-module, rr_pick (inputs: req, lp; outputs: any, w).
REQ-030 The FSM and all registered outputs SHALL remain in fifo_wr_arbiter.

Verification
REQ-031 Reset: rst=1 mid-GRANT -> gnt=0 and fifo_wr=0 immediately; stall_cnt=0 after release.
REQ-032 Single request: req=4'b0100 with data 3'd5, full=0 -> one cycle later gnt=4'b0100, fifo_wr=1, fifo_datin=5; next cycle all outputs are low.
REQ-033 Fairness: req=4'b1111 held with rotating data -> grant order 0,1,2,3,0 with a strobe every 2 cycles.
REQ-034 Full stall: full=1 with req=4'b0010 for 10 cycles -> no fifo_wr and stall_cnt=10; full=0 -> grant to 1 on the next edge.
REQ-035 Saturation: full=1 with req held for 300 cycles -> stall_cnt=255.
REQ-036 Withdrawal: in STALL, req drops to 0 -> IDLE next edge with no grant issued.
